// File: rtl/ram.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : ram
// Description : Single-port synchronous RAM used as the general-purpose
//               data/instruction store of the processor cores. One shared
//               address, one write port and one registered read port.
//               Writes commit on the rising clk edge. Reads have a 1-cycle
//               latency and are write-first: the word being written appears
//               on dataOut the cycle after the write.
// Ports       : clk     - clock, all state changes on the rising edge
//               rst     - synchronous active-high reset. It clears dataOut
//                         and blocks writes. It never clears stored words.
//               wrEn    - write enable
//               address - word address shared by read and write
//               dataIn  - write data
//               dataOut - registered read data
// Config      : RAM_INIT_ZERO_EN - when defined, every word powers up as 0.
//               When undefined, the array is left uninitialised.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module ram #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wrEn,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic [DATA_WIDTH-1:0] dataOut
);

  // The power-up value of 0 comes from a declaration initialiser.
  // The array itself has no reset.
  logic [DATA_WIDTH-1:0] r_dataOut = '0;
  logic                  w_inRange;

`ifdef RAM_INIT_ZERO_EN
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1] = '{default: '0};
`else
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
`endif

  // When the address space covers exactly DEPTH words, every address is valid.
  // In that case no comparator is built.
  generate
    if (DEPTH == (1 << ADDR_WIDTH)) begin : g_fullRange
      assign w_inRange = 1'b1;
    end else begin : g_partialRange
      localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
      assign w_inRange = ({1'b0, address} < c_DEPTH);
    end
  endgenerate

  // Array write. rst takes priority, so a reset cycle never corrupts stored data.
  always_ff @(posedge clk) begin
    if (!rst && wrEn && w_inRange) begin
      r_mem[address] <= dataIn;
    end
  end

  // Registered read port (write-first). Out-of-range accesses read as 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dataOut <= '0;
    end else if (!w_inRange) begin
      r_dataOut <= '0;
    end else if (wrEn) begin
      r_dataOut <= dataIn;
    end else begin
      r_dataOut <= r_mem[address];
    end
  end

  assign dataOut = r_dataOut;

endmodule
`default_nettype wire

// File: tb/tb_ram.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_ram
// Description : Directed self-checking bench for ram (DATA_WIDTH=12, DEPTH=8).
//               Inputs change 2ns after the falling edge. dataOut is sampled
//               at the same point, once each rising edge has taken effect.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_ram;

  localparam int c_DW = 12;
  localparam int c_DEPTH = 8;
  localparam int c_AW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            wrEn;
  logic [c_AW-1:0] address;
  logic [c_DW-1:0] dataIn;
  logic [c_DW-1:0] dataOut;

  int passCount = 0;
  int totalCount = 0;

  logic [c_DW-1:0] model [0:c_DEPTH-1];

  ram #(
    .DATA_WIDTH(c_DW),
    .DEPTH     (c_DEPTH),
    .ADDR_WIDTH(c_AW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wrEn   (wrEn),
    .address(address),
    .dataIn (dataIn),
    .dataOut(dataOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [c_DW-1:0] expVal);
    totalCount++;
    assert (dataOut === expVal) passCount++;
    else $error("FAIL %s: dataOut=%h expected %h", tag, dataOut, expVal);
  endtask

  // A build without zero initialisation has no defined value for unwritten words.
  // Such a word must at least not show data that a blocked write tried to store.
  task automatic checkNot(input string tag, input logic [c_DW-1:0] badVal);
    totalCount++;
    assert (dataOut !== badVal) passCount++;
    else $error("FAIL %s: dataOut=%h must differ from %h", tag, dataOut, badVal);
  endtask

  // Apply one set of inputs across one rising edge. Return at negedge+2ns.
  task automatic step(input logic r, input logic we, input logic [c_AW-1:0] a,
                      input logic [c_DW-1:0] d);
    rst = r;
    wrEn = we;
    address = a;
    dataIn = d;
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < c_DEPTH; i++) model[i] = '0;

    // Power-up value, before any edge
    rst = 1'b1; wrEn = 1'b1; address = 3'd5; dataIn = 12'hABC;
    #2;
    check("powerup", 12'h000);

    // Test 1: reset blocks the write
    step(1'b1, 1'b1, 3'd5, 12'hABC);
    check("t1_reset_out", 12'h000);
    step(1'b0, 1'b0, 3'd5, 12'h000);
`ifdef RAM_INIT_ZERO_EN
    check("t1_write_blocked", 12'h000);
`else
    checkNot("t1_write_blocked", 12'hABC);
`endif

    // Test 2: write-first, then read back
    step(1'b0, 1'b1, 3'd3, 12'h064);
    model[3] = 12'h064;
    check("t2_write_first", 12'h064);
    step(1'b0, 1'b0, 3'd3, 12'h000);
    check("t2_readback", 12'h064);

    // Test 3: unwritten address
    step(1'b0, 1'b0, 3'd2, 12'h000);
`ifdef RAM_INIT_ZERO_EN
    check("t3_unwritten", 12'h000);
`else
    checkNot("t3_unwritten", 12'h064);
`endif

    // Test 4: fill 0x111..0x888, read back in reverse order
    for (int i = 0; i < c_DEPTH; i++) begin
      logic [c_DW-1:0] v;
      v = 12'(12'h111 * (i + 1));
      step(1'b0, 1'b1, 3'(i), v);
      model[i] = v;
      check("t4_fill", v);
    end
    for (int i = c_DEPTH - 1; i >= 0; i--) begin
      step(1'b0, 1'b0, 3'(i), 12'h000);
      check("t4_read", 12'(12'h111 * (i + 1)));
    end

    // Back-to-back writes to one address: the last write wins
    step(1'b0, 1'b1, 3'd6, 12'h123);
    check("b2b_first", 12'h123);
    step(1'b0, 1'b1, 3'd6, 12'h456);
    check("b2b_second", 12'h456);
    step(1'b0, 1'b0, 3'd6, 12'h000);
    check("b2b_read", 12'h456);
    model[6] = 12'h456;

    // Test 5: random traffic against the model
    for (int n = 0; n < 24; n++) begin
      logic            we;
      logic [c_AW-1:0] a;
      logic [c_DW-1:0] d;
      we = 1'($urandom_range(0, 1));
      a = 3'($urandom_range(0, c_DEPTH - 1));
      d = 12'($urandom);
      if (we) model[a] = d;
      step(1'b0, we, a, d);
      check("t5_random", model[a]);
    end

    // Test 6: reset mid-operation keeps stored data
    step(1'b0, 1'b1, 3'd4, 12'hFFF);
    check("t6_write", 12'hFFF);
    step(1'b1, 1'b1, 3'd4, 12'h000);
    check("t6_reset_out", 12'h000);
    step(1'b0, 1'b0, 3'd4, 12'h000);
    check("t6_retained", 12'hFFF);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
`default_nettype wire
